// File: rtl/tt_um_matthias_m_pal_top_wrapper.sv
// Serially programmed PAL: an 8-input, 11-term, 5-output sum-of-products plane in the TinyTapeout wrapper.
// Optional build macro PAL_READBACK_EN drives cfg[0] on uio_out[3] so the chain can be read back.
module tt_um_matthias_m_pal_top_wrapper #(
    parameter int NUM_INPUTS        = 8,
    parameter int NUM_INTERM_STAGES = 11,
    parameter int NUM_OUTPUTS       = 5
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int TERM_W        = 2 * NUM_INPUTS;
    localparam int OR_BASE       = TERM_W * NUM_INTERM_STAGES;
    localparam int BITSTREAM_LEN = OR_BASE + NUM_INTERM_STAGES * NUM_OUTPUTS;

    logic                         cfg_in;
    logic                         enable;
    logic                         clk_pal;
    logic [BITSTREAM_LEN-1:0]     cfg;
    logic [NUM_INTERM_STAGES-1:0] terms;
    logic [NUM_OUTPUTS-1:0]       f;
    logic                         lit_any;
    logic                         prod;

    assign cfg_in  = uio_in[0];
    assign enable  = uio_in[1];
    assign clk_pal = uio_in[2];

    wire unused_pins = &{1'b0, ena, clk, uio_in[7:3]};

    // rst_n is active-high despite its name; shifting is frozen while the PAL is enabled.
    always_ff @(posedge clk_pal) begin
        if (rst_n) begin
            cfg <= '0;
        end else if (!enable) begin
            cfg <= {cfg_in, cfg[BITSTREAM_LEN-1:1]};
        end
    end

    // A term with no literal selected must read 0, not the empty-AND value of 1.
    always_comb begin
        terms   = '0;
        lit_any = 1'b0;
        prod    = 1'b1;
        for (int t = 0; t < NUM_INTERM_STAGES; t++) begin
            lit_any = 1'b0;
            prod    = 1'b1;
            for (int k = 0; k < NUM_INPUTS; k++) begin
                lit_any = lit_any | cfg[TERM_W*t + 2*k] | cfg[TERM_W*t + 2*k + 1];
                if (cfg[TERM_W*t + 2*k] && !ui_in[k]) begin
                    prod = 1'b0;
                end
                if (cfg[TERM_W*t + 2*k + 1] && ui_in[k]) begin
                    prod = 1'b0;
                end
            end
            terms[t] = prod & lit_any;
        end
    end

    always_comb begin
        f = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            f[o] = |(terms & cfg[OR_BASE + NUM_INTERM_STAGES*o +: NUM_INTERM_STAGES]);
        end
    end

    always_comb begin
        uo_out                  = '0;
        uo_out[NUM_OUTPUTS-1:0] = enable ? f : '0;
    end

`ifdef PAL_READBACK_EN
    always_comb begin
        uio_out    = '0;
        uio_out[3] = cfg[0];
        uio_oe     = 8'b0000_1000;
    end
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_matthias_m_pal_top_wrapper.sv
// Directed, table-driven bench for the serially programmed PAL wrapper.
module tb_tt_um_matthias_m_pal_top_wrapper;

    logic       clk_pal = 1'b0;
    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       enable  = 1'b0;
    logic       cfg_in  = 1'b0;
    logic       ena     = 1'b1;
    logic [7:0] ui_in   = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uio_in;

    int errors = 0;
    int checks = 0;

    assign uio_in = {5'b0, clk_pal, enable, cfg_in};

    always #5 clk_pal = ~clk_pal;
    always #7 clk = ~clk;

    tt_um_matthias_m_pal_top_wrapper dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    typedef struct {
        logic [7:0] ui;
        logic       en;
        logic [7:0] expected;
        string      name;
    } vec_t;

    vec_t       vecs_a[10];
    logic [230:0] prog_a;
    logic [230:0] prog_b;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] ui, input logic en);
        ui_in  = ui;
        enable = en;
        #1;
    endtask

    task automatic loadStream(input logic [230:0] bits);
        for (int i = 0; i < 231; i++) begin
            @(negedge clk_pal);
            enable = 1'b0;
            cfg_in = bits[i];
            @(posedge clk_pal);
        end
        @(negedge clk_pal);
        cfg_in = 1'b0;
    endtask

    task automatic runTableA(input string tag);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs_a[i].ui, vecs_a[i].en);
            checkOutput({tag, "_", vecs_a[i].name}, uo_out, vecs_a[i].expected);
        end
    endtask

    initial begin
        // O0 = ~I0 | I1&~I2 | I1&~I3
        prog_a = '0;
        prog_a[1] = 1'b1;   prog_a[18] = 1'b1;  prog_a[21] = 1'b1;
        prog_a[34] = 1'b1;  prog_a[39] = 1'b1;
        prog_a[176] = 1'b1; prog_a[177] = 1'b1; prog_a[178] = 1'b1;
        // O1 = I2
        prog_b = '0;
        prog_b[4] = 1'b1;   prog_b[187] = 1'b1;

        vecs_a[0] = '{8'h00, 1'b1, 8'h01, "ui00"};
        vecs_a[1] = '{8'h01, 1'b1, 8'h00, "ui01"};
        vecs_a[2] = '{8'h03, 1'b1, 8'h01, "ui03"};
        vecs_a[3] = '{8'h07, 1'b1, 8'h01, "ui07"};
        vecs_a[4] = '{8'h0F, 1'b1, 8'h00, "ui0F"};
        vecs_a[5] = '{8'hF0, 1'b1, 8'h01, "uiF0"};
        vecs_a[6] = '{8'h0B, 1'b1, 8'h01, "ui0B"};
        vecs_a[7] = '{8'h0D, 1'b1, 8'h00, "ui0D"};
        vecs_a[8] = '{8'h00, 1'b0, 8'h00, "disabled"};
        vecs_a[9] = '{8'h00, 1'b1, 8'h01, "reenabled"};

        // Reset for one edge, then check the cleared plane.
        rst_n = 1'b1;
        @(posedge clk_pal);
        @(negedge clk_pal);
        rst_n = 1'b0;
        applyStimulus(8'h00, 1'b1);
        checkOutput("reset_ui00", uo_out, 8'h00);
        checkOutput("reset_uio_out", uio_out, 8'h00);
`ifdef PAL_READBACK_EN
        checkOutput("reset_uio_oe", uio_oe, 8'h08);
`else
        checkOutput("reset_uio_oe", uio_oe, 8'h00);
`endif
        applyStimulus(8'hFF, 1'b1);
        checkOutput("reset_uiFF", uo_out, 8'h00);

        loadStream(prog_a);
        runTableA("progA");
        checkOutput("progA_uio_out_off", uio_out & 8'hF7, 8'h00);

        // Clocking with enable high must not disturb the loaded plane.
        @(negedge clk_pal);
        applyStimulus(8'h00, 1'b1);
        cfg_in = 1'b1;
        repeat (10) @(posedge clk_pal);
        @(negedge clk_pal);
        cfg_in = 1'b0;
        runTableA("hold");

        // Reset must win over a simultaneous shift.
        @(negedge clk_pal);
        enable = 1'b0;
        cfg_in = 1'b1;
        repeat (20) @(posedge clk_pal);
        @(negedge clk_pal);
        rst_n = 1'b1;
        @(posedge clk_pal);
        @(negedge clk_pal);
        rst_n  = 1'b0;
        cfg_in = 1'b0;
        applyStimulus(8'h00, 1'b1);
        checkOutput("rstwin_ui00", uo_out, 8'h00);
        applyStimulus(8'hF0, 1'b1);
        checkOutput("rstwin_uiF0", uo_out, 8'h00);

        loadStream(prog_b);
        applyStimulus(8'h04, 1'b1);
        checkOutput("progB_ui04", uo_out, 8'h02);
        applyStimulus(8'h00, 1'b1);
        checkOutput("progB_ui00", uo_out, 8'h00);
        applyStimulus(8'hFF, 1'b1);
        checkOutput("progB_uiFF", uo_out, 8'h02);
        applyStimulus(8'hFB, 1'b1);
        checkOutput("progB_uiFB", uo_out, 8'h00);

`ifdef PAL_READBACK_EN
        begin
            int bad = 0;
            @(negedge clk_pal);
            enable = 1'b0;
            cfg_in = 1'b0;
            for (int i = 0; i < 231; i++) begin
                #1;
                if (uio_out[3] !== prog_b[i]) bad++;
                @(posedge clk_pal);
                @(negedge clk_pal);
            end
            checkOutput("readback_bad_bits", bad[7:0], 8'h00);
            applyStimulus(8'hFF, 1'b1);
            checkOutput("readback_drained", uo_out, 8'h00);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
